// File: rtl/tx_module_pkg.sv
// rtl/tx_module_pkg.sv - UART Tx state encodings, conf field offsets and config decode helpers
package tx_module_pkg;

  // Send* codes match the Recv* codes used by the Rx path
  localparam logic [2:0] ST_RESET       = 3'd0;
  localparam logic [2:0] ST_IDLE        = 3'd1;
  localparam logic [2:0] ST_SEND_START  = 3'd2;
  localparam logic [2:0] ST_SEND_DATA   = 3'd3;
  localparam logic [2:0] ST_SEND_PARITY = 3'd4;
  localparam logic [2:0] ST_SEND_STOP   = 3'd5;
  localparam logic [2:0] ST_DONE        = 3'd6;

  localparam int SAMPLE_COUNTER_MAX = 15;

  localparam int PARITY_BIT = 0;
  localparam int STOP_LSB   = 1;
  localparam int DATA_LSB   = 3;

  function automatic int data_bits(input int data_field);
    return 5 + data_field;
  endfunction

endpackage

// File: rtl/tx_module.sv
// rtl/tx_module.sv - UART transmit engine: 5-8 data bits, optional even parity, 1-4 stop bits
module tx_module
  import tx_module_pkg::*;
#(
  parameter int MAX_UART_DATA_W      = 8,
  parameter int STOP_CONF_WIDTH      = 2,
  parameter int DATA_CONF_WIDTH      = 2,
  parameter int SAMPLE_COUNTER_WIDTH = 4,
  parameter int TOTAL_CONF_WIDTH     = 5
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        baud_en_i,
  input  logic                        tx_en_i,
  input  logic [TOTAL_CONF_WIDTH-1:0] tx_conf_i,
  input  logic                        tx_start_i,
  input  logic [MAX_UART_DATA_W-1:0]  tx_data_i,
  output logic                        tx_ready_o,
  output logic                        tx_busy_o,
  output logic                        tx_done_o,
  output logic                        uart_tx_o
);

  localparam int DATA_CNT_W = $clog2(MAX_UART_DATA_W);

  logic [2:0]                      state_q, state_d;
  logic [SAMPLE_COUNTER_WIDTH-1:0] sample_q, sample_d;
  logic [DATA_CNT_W-1:0]           data_cnt_q, data_cnt_d;
  logic [STOP_CONF_WIDTH-1:0]      stop_cnt_q, stop_cnt_d;
  logic [MAX_UART_DATA_W-1:0]      data_q, data_masked;
  logic [DATA_CONF_WIDTH-1:0]      data_conf_q, data_conf_in;
  logic [STOP_CONF_WIDTH-1:0]      stop_conf_q;
  logic                            parity_en_q, pending_q, busy_q;
  logic                            accept, last_sample, last_data_bit, in_send;
  logic                            clr_pending, frame_end, line_d;

  assign tx_ready_o   = (state_q == ST_IDLE) && !pending_q;
  assign tx_busy_o    = busy_q;
  assign accept       = tx_start_i && tx_ready_o;
  assign data_conf_in = tx_conf_i[DATA_LSB +: DATA_CONF_WIDTH];

  assign in_send       = (state_q == ST_SEND_START) || (state_q == ST_SEND_DATA) ||
                         (state_q == ST_SEND_PARITY) || (state_q == ST_SEND_STOP);
  assign last_sample   = (sample_q == SAMPLE_COUNTER_WIDTH'(SAMPLE_COUNTER_MAX));
  assign last_data_bit = (int'(data_cnt_q) == data_bits(int'(data_conf_q)) - 1);

  // Unused upper bits are zeroed so the parity XOR can cover the whole register
  always_comb begin
    data_masked = '0;
    for (int i = 0; i < MAX_UART_DATA_W; i++) begin
      if (i < data_bits(int'(data_conf_in))) data_masked[i] = tx_data_i[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    sample_d    = sample_q;
    data_cnt_d  = data_cnt_q;
    stop_cnt_d  = stop_cnt_q;
    clr_pending = 1'b0;
    frame_end   = 1'b0;
    if (in_send) sample_d = last_sample ? '0 : sample_q + SAMPLE_COUNTER_WIDTH'(1);
    case (state_q)
      ST_RESET:      if (tx_en_i) state_d = ST_IDLE;
      ST_IDLE: begin
        if (pending_q) begin
          state_d     = ST_SEND_START;
          clr_pending = 1'b1;
        end
      end
      ST_SEND_START: if (last_sample) state_d = ST_SEND_DATA;
      ST_SEND_DATA: begin
        if (last_sample) begin
          if (last_data_bit) begin
            data_cnt_d = '0;
            state_d    = parity_en_q ? ST_SEND_PARITY : ST_SEND_STOP;
          end else begin
            data_cnt_d = data_cnt_q + DATA_CNT_W'(1);
          end
        end
      end
      ST_SEND_PARITY: if (last_sample) state_d = ST_SEND_STOP;
      ST_SEND_STOP: begin
        if (last_sample) begin
          if (stop_cnt_q == stop_conf_q) begin
            stop_cnt_d = '0;
            state_d    = ST_DONE;
          end else begin
            stop_cnt_d = stop_cnt_q + STOP_CONF_WIDTH'(1);
          end
        end
      end
      ST_DONE: begin
        frame_end = 1'b1;
        state_d   = tx_en_i ? ST_IDLE : ST_RESET;
      end
      default: state_d = ST_RESET;
    endcase
  end

  // Line level is chosen from the next state so it is registered in step with the FSM
  always_comb begin
    line_d = 1'b1;
    case (state_d)
      ST_SEND_START:  line_d = 1'b0;
      ST_SEND_DATA:   line_d = data_q[data_cnt_d];
      ST_SEND_PARITY: line_d = ^data_q;
      default:        line_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_RESET;
      sample_q    <= '0;
      data_cnt_q  <= '0;
      stop_cnt_q  <= '0;
      data_q      <= '0;
      data_conf_q <= '0;
      stop_conf_q <= '0;
      parity_en_q <= 1'b0;
      pending_q   <= 1'b0;
      busy_q      <= 1'b0;
      tx_done_o   <= 1'b0;
      uart_tx_o   <= 1'b1;
    end else begin
      tx_done_o <= 1'b0;
      if (accept) begin
        data_q      <= data_masked;
        data_conf_q <= data_conf_in;
        stop_conf_q <= tx_conf_i[STOP_LSB +: STOP_CONF_WIDTH];
        parity_en_q <= tx_conf_i[PARITY_BIT];
        pending_q   <= 1'b1;
        busy_q      <= 1'b1;
      end
      if (baud_en_i) begin
        state_q    <= state_d;
        sample_q   <= sample_d;
        data_cnt_q <= data_cnt_d;
        stop_cnt_q <= stop_cnt_d;
        uart_tx_o  <= line_d;
        if (clr_pending) pending_q <= 1'b0;
        if (frame_end) begin
          tx_done_o <= 1'b1;
          busy_q    <= 1'b0;
        end
      end
    end
  end

endmodule
